i2c_burst_sequencer: RTL
========================

Name: i2c_burst_sequencer

Overview:
- Upstream command stage for the I2C byte-memory transaction core.
- Accepts burst commands: start address, byte count, read/write. Issues them as a series of single-byte transactions on the core's wr/addr/din interface, one address at a time.
- Collects read bytes from the core's datard/done outputs into a valid/ready output stream.
- Because the core free-runs transactions from idle, this block owns all sequencing, stability, and timeout policy.

Parameters:
- LEN_W, 4, width of cmd_len; burst length = cmd_len+1 (1..16 bytes).
- TIMEOUT, 1024, cycles allowed per byte between output change and accepted done before abort.
- TO_W, 11, width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_wr  in  1  1=write burst, 0=read burst
- cmd_addr  in  7  start address
- cmd_len  in  LEN_W  byte count minus one
- wdata_valid  in  1  write byte offered
- wdata_ready  out  1  write byte popped when valid&&ready
- wdata  in  8  write byte
- rdata_valid  out  1  read byte available
- rdata_ready  in  1  downstream accepts read byte
- rdata  out  8  read byte
- mem_wr  out  1  to core wr
- mem_addr  out  7  to core addr
- mem_din  out  8  to core din
- mem_datard  in  8  from core datard
- mem_done  in  1  from core done (1-cycle pulse)
- busy  out  1  burst in progress
- err  out  1  1-cycle pulse on timeout abort

Behaviour:
- Reset values: cmd_ready=0, wdata_ready=0, rdata_valid=0, rdata=0, mem_wr=0, mem_addr=0, mem_din=0, busy=0, err=0. State=IDLE. Internal counters = 0.
- Reset mid-burst aborts immediately. No further wdata pops occur. Any pending rdata is dropped.
- cmd_ready=1 only in IDLE and not in reset. On accept, latch wr/addr/len and go to LOAD next cycle. busy=1 from that cycle until return to IDLE.
- States: IDLE, LOAD, ISSUE, WAIT, STORE, DRAIN.
- LOAD:
  - Write burst: wdata_ready=1 for the cycle wdata_valid is seen. The popped byte is registered to mem_din, and mem_addr/mem_wr are updated in the same edge, then go to ISSUE. While wdata_valid=0, stay in LOAD (no timeout counting).
  - Read burst: drive mem_addr/mem_wr=0, mem_din unchanged, go to ISSUE in 1 cycle.
- ISSUE: clear skip flag to 0 and the timeout counter, then go to WAIT.
- WAIT: the core may already be mid-transaction with old values.
  - The first mem_done after ISSUE is discarded (skip flag set to 1).
  - The second mem_done is accepted.
  - The timeout counter increments every WAIT cycle.
- On accepted done:
  - Read burst: capture mem_datard into rdata, set rdata_valid=1, go to STORE.
  - Write burst: go to STORE directly.
- STORE:
  - Read: hold until rdata_valid&&rdata_ready, then clear rdata_valid.
  - Write: 1 cycle.
  - Then, if bytes remain: mem_addr+1 mod 128 (127 wraps to 0), decrement remaining, go to LOAD. Otherwise go to IDLE.
- Outputs mem_wr/mem_addr/mem_din change only at LOAD exit. They are stable from ISSUE through STORE.
- Timeout: counter reaches TIMEOUT-1 in WAIT without an accepted done →
  - err=1 for one cycle.
  - Read burst: go to IDLE. Remaining bytes are not produced.
  - Write burst: go to DRAIN, which pops and discards exactly the remaining count of wdata bytes (wdata_ready=1) so upstream framing stays aligned, then go to IDLE.
- mem_done outside WAIT is ignored.
- A new cmd_valid while busy is ignored (cmd_ready=0).

Test Plan:
- Write addr 0x10 len 0, wdata 0xA5 → one wdata pop; mem_addr=0x10, mem_wr=1, mem_din=0xA5; second done accepted; busy low within 2 cycles; core mem[0x10]=0xA5.
- Preload core mem[0x20..0x22]=0x11,0x22,0x33; read 0x20 len 2 with rdata_ready low 5 cycles per byte → rdata 0x11,0x22,0x33 in order; each held stable until ready; mem_addr never advances while rdata_valid=1.
- Write addr 0x7E len 2, data 0x01,0x02,0x03 → mem_addr sequence 0x7E,0x7F,0x00; core mem holds those values.
- Core done tied low, write len 3, TIMEOUT=16 → err pulse 16 cycles into WAIT; DRAIN pops remaining 3 bytes; cmd_ready=1 afterwards.
- rst asserted during WAIT of byte 2 of a read burst → next cycle all outputs at reset values; a fresh single read is served correctly.
- Write burst with wdata_valid low 10 cycles between bytes → no err; mem outputs unchanged during starvation; all bytes written.

Source files
------------

// File: rtl/i2c_burst_sequencer.sv
// Burst command sequencer: splits address/length bursts into single-byte core transactions.
// Latency: per byte LOAD->ISSUE->WAIT(two core dones)->STORE; read bytes registered into rdata.
// Backpressure: cmd/wdata/rdata valid-ready; rdata held until accepted, core outputs frozen meanwhile.
module i2c_burst_sequencer #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [6:0]       cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [7:0]       wdata,
    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic [7:0]       rdata,
    output logic             mem_wr,
    output logic [6:0]       mem_addr,
    output logic [7:0]       mem_din,
    input  logic [7:0]       mem_datard,
    input  logic             mem_done,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        STORE = 3'd4,
        DRAIN = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             wr_q;       // direction of the burst in progress
    logic [6:0]       cur_addr;   // address of the byte being worked on
    logic [LEN_W-1:0] rem;        // bytes still to do after the current one
    logic             skip;       // first done after ISSUE has been discarded
    logic [TO_W-1:0]  to_cnt;
    logic             accept;
    logic             load_go;
    logic             done_ok;
    logic             timeout;
    logic             store_go;

    // Next-state decode plus the combinational handshake outputs.
    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        busy        = (state != IDLE);
        accept      = 1'b0;
        load_go     = 1'b0;
        done_ok     = 1'b0;
        timeout     = 1'b0;
        store_go    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                // A write byte is popped only when the upstream actually offers one;
                // starvation here is not a core stall, so nothing is timed.
                if (wr_q) begin
                    wdata_ready = wdata_valid;
                    load_go     = wdata_valid;
                end else begin
                    load_go = 1'b1;
                end
                if (load_go) state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // The core may be mid-transaction on stale values, so only the
                // second done after ISSUE is trusted.
                if (mem_done && skip) begin
                    done_ok   = 1'b1;
                    state_nxt = STORE;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = (wr_q && rem != '0) ? DRAIN : IDLE;
                end
            end
            STORE: begin
                store_go = wr_q ? 1'b1 : (rdata_valid && rdata_ready);
                if (store_go) state_nxt = (rem != '0) ? LOAD : IDLE;
            end
            DRAIN: begin
                // Swallow the write bytes the aborted burst would have used.
                wdata_ready = 1'b1;
                if (wdata_valid && rem == LEN_W'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and burst datapath; core-facing outputs move only on LOAD exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_q        <= 1'b0;
            cur_addr    <= '0;
            rem         <= '0;
            skip        <= 1'b0;
            to_cnt      <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= timeout;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_q     <= cmd_wr;
                        cur_addr <= cmd_addr;
                        rem      <= cmd_len;
                    end
                end
                LOAD: begin
                    if (load_go) begin
                        mem_addr <= cur_addr;
                        mem_wr   <= wr_q;
                        if (wr_q) mem_din <= wdata;
                    end
                end
                ISSUE: begin
                    skip   <= 1'b0;
                    to_cnt <= '0;
                end
                WAIT: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (mem_done && !skip) skip <= 1'b1;
                    if (done_ok && !wr_q) begin
                        rdata       <= mem_datard;
                        rdata_valid <= 1'b1;
                    end
                end
                STORE: begin
                    if (store_go) begin
                        rdata_valid <= 1'b0;
                        if (rem != '0) begin
                            cur_addr <= cur_addr + 7'd1;
                            rem      <= rem - LEN_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (wdata_valid) rem <= rem - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
